// File: rtl/rob_commit_if.sv
// Dispatch, completion, retire and committed-map signals of the reorder buffer.
// master = surrounding pipeline, slave = rob_commit.
interface rob_commit_if #(
  parameter int DEPTH = 32,
  parameter int NPHYS = 32
);
  localparam int TW = $clog2(DEPTH);
  localparam int PW = $clog2(NPHYS);

  logic                  freeze_front;
  logic                  valid_pc_r_r;
  logic [2:0][1:0]       Type_r;
  logic [2:0][PW-1:0]    Pw;
  logic [2:0][PW-1:0]    Pw_old;
  logic [2:0][2:0]       Rw_r;
  logic [2:0][TW-1:0]    tag_ROB;
  logic                  full_ROB;

  logic                  valid_Result_add;
  logic                  valid_Result_mul;
  logic                  valid_Result_ls;
  logic [TW-1:0]         tag_ROB_Result_add;
  logic [TW-1:0]         tag_ROB_Result_mul;
  logic [TW-1:0]         tag_ROB_Result_ls;
  logic                  excep_ls;

  logic [2:0]            ready_ret;
  logic [2:0]            excep_ret;
  logic [2:0][1:0]       Type_ret;
  logic [2:0][PW-1:0]    Pw_old_ret;
  logic                  flush;
  logic [7:0][PW-1:0]    ARAT_P_list;
  logic [NPHYS-1:0]      ARAT_freelist;

  modport master (
    output freeze_front, valid_pc_r_r, Type_r, Pw, Pw_old, Rw_r,
    output valid_Result_add, valid_Result_mul, valid_Result_ls,
    output tag_ROB_Result_add, tag_ROB_Result_mul, tag_ROB_Result_ls, excep_ls,
    input  tag_ROB, full_ROB, ready_ret, excep_ret, Type_ret, Pw_old_ret,
    input  flush, ARAT_P_list, ARAT_freelist
  );

  modport slave (
    input  freeze_front, valid_pc_r_r, Type_r, Pw, Pw_old, Rw_r,
    input  valid_Result_add, valid_Result_mul, valid_Result_ls,
    input  tag_ROB_Result_add, tag_ROB_Result_mul, tag_ROB_Result_ls, excep_ls,
    output tag_ROB, full_ROB, ready_ret, excep_ret, Type_ret, Pw_old_ret,
    output flush, ARAT_P_list, ARAT_freelist
  );
endinterface

// File: rtl/rob_commit.sv
// 3-wide reorder buffer: in-order allocate, out-of-order complete, in-order retire,
// plus the committed (architectural) RAT and freelist used for exception recovery.
module rob_commit #(
  parameter int DEPTH = 32,
  parameter int NPHYS = 32
) (
  input  logic         clk,
  input  logic         rst,
  rob_commit_if.slave  rob
);
  localparam int TW    = $clog2(DEPTH);
  localparam int PW    = $clog2(NPHYS);
  localparam int CW    = TW + 1;
  localparam int NARCH = 8;
  localparam logic [NPHYS-1:0] FREELIST_RST = {{(NPHYS-NARCH){1'b1}}, {NARCH{1'b0}}};

  typedef logic [TW-1:0] tag_t;

  logic [DEPTH-1:0]          valid_q, valid_d, done_q, done_d, excep_q, excep_d;
  logic [1:0]                type_q [DEPTH];
  logic [1:0]                type_d [DEPTH];
  logic [2:0]                rw_q [DEPTH];
  logic [2:0]                rw_d [DEPTH];
  logic [PW-1:0]             pw_q [DEPTH];
  logic [PW-1:0]             pw_d [DEPTH];
  logic [PW-1:0]             pw_old_q [DEPTH];
  logic [PW-1:0]             pw_old_d [DEPTH];
  tag_t                      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      flush_q, flush_d;
  logic [NARCH-1:0][PW-1:0]  arat_q, arat_d;
  logic [NPHYS-1:0]          freelist_q, freelist_d;

  tag_t       slot_tag [3];
  logic [2:0] ready, excep_r;
  logic [1:0] n_ret;
  logic       full, alloc;

  assign full  = count_q > CW'(DEPTH - 3);
  assign alloc = rob.valid_pc_r_r & ~rob.freeze_front & ~flush_q & ~full;
  assign n_ret = 2'($countones(ready));

  // A slot retires only behind ready, non-excepting slots; the excepting slot
  // itself still retires so the flush can be raised behind it.
  always_comb begin
    logic lower_ok;
    lower_ok = ~flush_q;
    for (int i = 0; i < 3; i++) begin
      slot_tag[i] = head_q + tag_t'(i);
      ready[i]    = lower_ok & valid_q[slot_tag[i]] & done_q[slot_tag[i]];
      excep_r[i]  = ready[i] & excep_q[slot_tag[i]];
      lower_ok    = ready[i] & ~excep_q[slot_tag[i]];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rob.tag_ROB[i]    = tail_q + tag_t'(i);
      rob.Type_ret[i]   = ready[i] ? type_q[slot_tag[i]] : 2'b00;
      rob.Pw_old_ret[i] = ready[i] ? pw_old_q[slot_tag[i]] : '0;
    end
  end

  assign rob.full_ROB      = full;
  assign rob.ready_ret     = ready;
  assign rob.excep_ret     = excep_r;
  assign rob.flush         = flush_q;
  assign rob.ARAT_P_list   = arat_q;
  assign rob.ARAT_freelist = freelist_q;

  always_comb begin
    tag_t t;
    // NOTE: every comb output starts from its held value, so no path leaves it unassigned (no latch).
    t          = '0;
    valid_d    = valid_q;
    done_d     = done_q;
    excep_d    = excep_q;
    type_d     = type_q;
    rw_d       = rw_q;
    pw_d       = pw_q;
    pw_old_d   = pw_old_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    arat_d     = arat_q;
    freelist_d = freelist_q;
    flush_d    = |excep_r;

    if (flush_q) begin
      valid_d = '0;
      done_d  = '0;
      excep_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rob.valid_Result_add && valid_q[rob.tag_ROB_Result_add]) done_d[rob.tag_ROB_Result_add] = 1'b1;
      if (rob.valid_Result_mul && valid_q[rob.tag_ROB_Result_mul]) done_d[rob.tag_ROB_Result_mul] = 1'b1;
      if (rob.valid_Result_ls && valid_q[rob.tag_ROB_Result_ls]) begin
        done_d[rob.tag_ROB_Result_ls]  = 1'b1;
        excep_d[rob.tag_ROB_Result_ls] = excep_d[rob.tag_ROB_Result_ls] | rob.excep_ls;
      end

      // NOTE: blocking updates in slot order make a later slot win on a shared Rw/Pw.
      for (int i = 0; i < 3; i++) begin
        if (ready[i]) begin
          t          = slot_tag[i];
          valid_d[t] = 1'b0;
          done_d[t]  = 1'b0;
          excep_d[t] = 1'b0;
          if (!excep_q[t] && type_q[t] != 2'b11) begin
            arat_d[rw_q[t]]         = pw_q[t];
            freelist_d[pw_q[t]]     = 1'b0;
            freelist_d[pw_old_q[t]] = 1'b1;
          end
        end
      end
      head_d = head_q + tag_t'(n_ret);

      if (alloc) begin
        for (int i = 0; i < 3; i++) begin
          t           = tail_q + tag_t'(i);
          valid_d[t]  = 1'b1;
          done_d[t]   = 1'b0;
          excep_d[t]  = 1'b0;
          type_d[t]   = rob.Type_r[i];
          rw_d[t]     = rob.Rw_r[i];
          pw_d[t]     = rob.Pw[i];
          pw_old_d[t] = rob.Pw_old[i];
        end
        tail_d = tail_q + tag_t'(3);
      end
      count_d = count_q + (alloc ? CW'(3) : CW'(0)) - CW'(n_ret);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      done_q     <= '0;
      excep_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      freelist_q <= FREELIST_RST;
      for (int i = 0; i < NARCH; i++) arat_q[i] <= PW'(i);
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      excep_q    <= excep_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      freelist_q <= freelist_d;
      arat_q     <= arat_d;
    end
  end

  // NOTE: payload storage has no reset; it is only observed through valid_q, which is reset.
  always_ff @(posedge clk) begin
    type_q   <= type_d;
    rw_q     <= rw_d;
    pw_q     <= pw_d;
    pw_old_q <= pw_old_d;
  end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: stimulus pushes expected retirements into a
// scoreboard queue that a negedge monitor drains; state checks are inline.
module tb_rob_commit;
  localparam int ADD = 0;
  localparam int MUL = 1;
  localparam int LS  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_commit_if #(.DEPTH(32), .NPHYS(32)) rif ();
  rob_commit #(.DEPTH(32), .NPHYS(32)) dut (.clk(clk), .rst(rst), .rob(rif));

  typedef struct {
    int         slot;
    logic [1:0] typ;
    logic [4:0] pw_old;
    logic       exc;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rif.valid_pc_r_r     = 1'b0;
    rif.valid_Result_add = 1'b0;
    rif.valid_Result_mul = 1'b0;
    rif.valid_Result_ls  = 1'b0;
    rif.excep_ls         = 1'b0;
  endtask

  task automatic slot(input int i, input logic [1:0] ty, input logic [2:0] rw,
                      input logic [4:0] pw, input logic [4:0] pwo);
    rif.Type_r[i]    = ty;
    rif.Rw_r[i]      = rw;
    rif.Pw[i]        = pw;
    rif.Pw_old[i]    = pwo;
    rif.valid_pc_r_r = 1'b1;
  endtask

  task automatic complete(input int unit, input logic [4:0] tag, input logic exc);
    case (unit)
      ADD: begin rif.valid_Result_add = 1'b1; rif.tag_ROB_Result_add = tag; end
      MUL: begin rif.valid_Result_mul = 1'b1; rif.tag_ROB_Result_mul = tag; end
      default: begin
        rif.valid_Result_ls  = 1'b1;
        rif.tag_ROB_Result_ls = tag;
        rif.excep_ls          = exc;
      end
    endcase
  endtask

  task automatic expect_ret(input int s, input logic [1:0] ty, input logic [4:0] pwo,
                            input logic exc, input int c);
    exp_q.push_back(exp_t'{slot: s, typ: ty, pw_old: pwo, exc: exc, cyc: c});
  endtask

  // Monitor: every retirement due this cycle must appear, and nothing else.
  always @(negedge clk) begin
    int   n;
    exp_t e;
    n = 0;
    if (rst === 1'b1) begin
      while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n++;
        check("ret_ready",  32'(rif.ready_ret[e.slot]), 32'd1);
        check("ret_type",   32'(rif.Type_ret[e.slot]), 32'(e.typ));
        check("ret_pw_old", 32'(rif.Pw_old_ret[e.slot]), 32'(e.pw_old));
        check("ret_excep",  32'(rif.excep_ret[e.slot]), 32'(e.exc));
      end
      check("ret_count", $countones(rif.ready_ret), n);
    end
  end

  initial begin
    int c;
    rst                    = 1'b0;
    rif.freeze_front       = 1'b0;
    rif.valid_pc_r_r       = 1'b0;
    rif.Type_r             = '0;
    rif.Rw_r               = '0;
    rif.Pw                 = '0;
    rif.Pw_old             = '0;
    rif.valid_Result_add   = 1'b0;
    rif.valid_Result_mul   = 1'b0;
    rif.valid_Result_ls    = 1'b0;
    rif.tag_ROB_Result_add = '0;
    rif.tag_ROB_Result_mul = '0;
    rif.tag_ROB_Result_ls  = '0;
    rif.excep_ls           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset values
    check("rst_tag0", rif.tag_ROB[0], 0);
    check("rst_tag1", rif.tag_ROB[1], 1);
    check("rst_tag2", rif.tag_ROB[2], 2);
    check("rst_full", rif.full_ROB, 0);
    check("rst_arat5", rif.ARAT_P_list[5], 5);
    check("rst_freelist", rif.ARAT_freelist, 32'hFFFF_FF00);
    check("rst_flush", rif.flush, 0);

    // In-order retire: complete 2, then 0 (retires alone), then 1 (1 and 2 retire)
    slot(0, 2'b00, 3'd1, 5'd8, 5'd1);
    slot(1, 2'b00, 3'd2, 5'd9, 5'd2);
    slot(2, 2'b00, 3'd3, 5'd10, 5'd3);
    step();
    check("alloc_tag0", rif.tag_ROB[0], 3);
    complete(ADD, 5'd2, 1'b0);
    step();
    c = cyc;
    complete(MUL, 5'd0, 1'b0);
    expect_ret(0, 2'b00, 5'd1, 1'b0, c + 1);
    step();
    c = cyc;
    complete(LS, 5'd1, 1'b0);
    expect_ret(0, 2'b00, 5'd2, 1'b0, c + 1);
    expect_ret(1, 2'b00, 5'd3, 1'b0, c + 1);
    step();
    check("io_arat1_early", rif.ARAT_P_list[1], 8);
    check("io_arat2_early", rif.ARAT_P_list[2], 2);
    step();
    check("io_arat1", rif.ARAT_P_list[1], 8);
    check("io_arat2", rif.ARAT_P_list[2], 9);
    check("io_arat3", rif.ARAT_P_list[3], 10);
    check("io_freelist", rif.ARAT_freelist, 32'hFFFF_F80E);

    // Store leaves the ARAT alone; two commits to Rw 4 in one cycle, later wins
    slot(0, 2'b11, 3'd6, 5'd20, 5'd21);
    slot(1, 2'b00, 3'd4, 5'd12, 5'd4);
    slot(2, 2'b00, 3'd4, 5'd13, 5'd12);
    step();
    check("st_tag0", rif.tag_ROB[0], 6);
    c = cyc;
    complete(ADD, 5'd5, 1'b0);
    complete(MUL, 5'd4, 1'b0);
    complete(LS, 5'd3, 1'b0);
    expect_ret(0, 2'b11, 5'd21, 1'b0, c + 1);
    expect_ret(1, 2'b00, 5'd4, 1'b0, c + 1);
    expect_ret(2, 2'b00, 5'd12, 1'b0, c + 1);
    step();
    step();
    check("samerw_arat4", rif.ARAT_P_list[4], 13);
    check("store_arat6", rif.ARAT_P_list[6], 6);
    check("st_freelist", rif.ARAT_freelist, 32'hFFFF_D81E);

    // Exception on slot 1 (load)
    slot(0, 2'b00, 3'd1, 5'd14, 5'd8);
    slot(1, 2'b10, 3'd2, 5'd15, 5'd9);
    slot(2, 2'b00, 3'd3, 5'd16, 5'd10);
    step();
    check("ex_tag0", rif.tag_ROB[0], 9);
    c = cyc;
    complete(ADD, 5'd6, 1'b0);
    complete(MUL, 5'd8, 1'b0);
    complete(LS, 5'd7, 1'b1);
    expect_ret(0, 2'b00, 5'd8, 1'b0, c + 1);
    expect_ret(1, 2'b10, 5'd9, 1'b1, c + 1);
    step();
    check("ex_ready", rif.ready_ret, 3'b011);
    check("ex_excep", rif.excep_ret, 3'b010);
    check("ex_flush_early", rif.flush, 0);
    step();
    check("ex_flush", rif.flush, 1);
    check("ex_arat1", rif.ARAT_P_list[1], 14);
    check("ex_arat2", rif.ARAT_P_list[2], 9);
    check("ex_arat3", rif.ARAT_P_list[3], 10);
    check("ex_freelist", rif.ARAT_freelist, 32'hFFFF_991E);
    slot(0, 2'b00, 3'd5, 5'd17, 5'd5);
    slot(1, 2'b00, 3'd5, 5'd18, 5'd17);
    slot(2, 2'b00, 3'd5, 5'd19, 5'd18);
    complete(ADD, 5'd8, 1'b0);
    step();
    check("ex_flush_end", rif.flush, 0);
    check("ex_tag0_after", rif.tag_ROB[0], 0);
    check("ex_tag1_after", rif.tag_ROB[1], 1);
    check("ex_tag2_after", rif.tag_ROB[2], 2);
    check("ex_full_after", rif.full_ROB, 0);

    // Fill to 30 entries, then drain while allocating across the wrap
    for (int g = 0; g < 10; g++) begin
      for (int i = 0; i < 3; i++) slot(i, 2'b00, 3'(i), 5'(3 * g + i), 5'(3 * g + i));
      step();
      if (g == 8) check("fill_full_27", rif.full_ROB, 0);
      if (g == 9) check("fill_full_30", rif.full_ROB, 1);
    end
    check("fill_tag0", rif.tag_ROB[0], 30);
    for (int i = 0; i < 3; i++) slot(i, 2'b01, 3'd7, 5'd1, 5'd1);
    c = cyc;
    complete(ADD, 5'd0, 1'b0);
    complete(MUL, 5'd1, 1'b0);
    complete(LS, 5'd2, 1'b0);
    for (int i = 0; i < 3; i++) expect_ret(i, 2'b00, 5'(i), 1'b0, c + 1);
    step();
    check("full_alloc_ignored", rif.tag_ROB[0], 30);
    check("full_still", rif.full_ROB, 1);
    for (int j = 1; j < 11; j++) begin
      c = cyc;
      if (j == 2) begin
        check("wrap_full", rif.full_ROB, 0);
        check("wrap_tag0", rif.tag_ROB[0], 30);
        check("wrap_tag1", rif.tag_ROB[1], 31);
        check("wrap_tag2", rif.tag_ROB[2], 0);
        for (int i = 0; i < 3; i++) slot(i, 2'b00, 3'(i), 5'(30 + i), 5'(30 + i));
      end
      complete(ADD, 5'(3 * j), 1'b0);
      complete(MUL, 5'(3 * j + 1), 1'b0);
      complete(LS, 5'(3 * j + 2), 1'b0);
      for (int i = 0; i < 3; i++) expect_ret(i, 2'b00, 5'(3 * j + i), 1'b0, c + 1);
      step();
    end
    step();
    check("wrap_tail", rif.tag_ROB[0], 1);
    check("wrap_empty_full", rif.full_ROB, 0);

    // Asynchronous reset with 21 live entries
    for (int g = 0; g < 7; g++) begin
      for (int i = 0; i < 3; i++) slot(i, 2'b01, 3'd0, 5'(1 + 3 * g + i), 5'(1 + 3 * g + i));
      step();
    end
    complete(ADD, 5'd1, 1'b0);
    complete(MUL, 5'd2, 1'b0);
    complete(LS, 5'd3, 1'b0);
    step();
    check("mid_ready_pre", rif.ready_ret, 3'b111);
    check("mid_pwold_pre", rif.Pw_old_ret[0], 1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_tag0", rif.tag_ROB[0], 0);
    check("mid_tag1", rif.tag_ROB[1], 1);
    check("mid_tag2", rif.tag_ROB[2], 2);
    check("mid_full", rif.full_ROB, 0);
    check("mid_ready", rif.ready_ret, 0);
    check("mid_excep", rif.excep_ret, 0);
    check("mid_type_ret", rif.Type_ret, 0);
    check("mid_pwold_ret", rif.Pw_old_ret, 0);
    check("mid_flush", rif.flush, 0);
    check("mid_arat4", rif.ARAT_P_list[4], 4);
    check("mid_freelist", rif.ARAT_freelist, 32'hFFFF_FF00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("post_rst_tag0", rif.tag_ROB[0], 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
